// File: rtl/bure_pkg.sv
// Shared types and opcode constants for the Bure core decode stage.
// Imported by the decoder and the ID-stage skid buffer.
package bure_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      OC_LUI     = 4'd0,
      OC_AUIPC   = 4'd1,
      OC_JAL     = 4'd2,
      OC_JALR    = 4'd3,
      OC_BRANCH  = 4'd4,
      OC_LOAD    = 4'd5,
      OC_STORE   = 4'd6,
      OC_ALU_IMM = 4'd7,
      OC_ALU_REG = 4'd8,
      OC_FENCE   = 4'd9,
      OC_SYSTEM  = 4'd10
   } bure_op_class_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } bure_alu_op_e;

   typedef struct packed {
      logic [31:0]    pc;
      logic [4:0]     rd;
      logic [4:0]     rs1;
      logic [4:0]     rs2;
      logic [31:0]    imm;
      bure_op_class_e op_class;
      bure_alu_op_e   alu_op;
      logic [2:0]     funct3;
      logic           rs1_en;
      logic           rs2_en;
      logic           rd_we;
      logic           illegal;
   } bure_dec_t;

   // alt selects SUB for funct3 000 and SRA for funct3 101
   function automatic bure_alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
      bure_alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/bure_decoder.sv
// Combinational RV32I decoder: instruction word + PC to bure_dec_t.
// Illegal encodings are flagged and have all enables cleared.
module bure_decoder
   import bure_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32
) (
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic [ADDR_WIDTH-1:0]  pc,
   output bure_dec_t              dec
);

   logic [6:0]            opcode_s;
   logic [2:0]            funct3_s;
   logic [6:0]            funct7_s;
   logic [DATA_WIDTH-1:0] imm_i_s;
   logic [DATA_WIDTH-1:0] imm_s_s;
   logic [DATA_WIDTH-1:0] imm_b_s;
   logic [DATA_WIDTH-1:0] imm_u_s;
   logic [DATA_WIDTH-1:0] imm_j_s;
   logic                  ill_s;

   assign opcode_s = instr[6:0];
   assign funct3_s = instr[14:12];
   assign funct7_s = instr[31:25];
   assign imm_i_s  = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
   assign imm_s_s  = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b_s  = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u_s  = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'h000};
   assign imm_j_s  = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Per-opcode field selection and legality, then enable masking
   always_comb begin
      dec        = '0;
      dec.pc     = pc;
      dec.rd     = instr[11:7];
      dec.rs1    = instr[19:15];
      dec.rs2    = instr[24:20];
      dec.funct3 = funct3_s;
      ill_s      = (instr[1:0] != 2'b11);
      case (opcode_s)
         OPC_LUI: begin
            dec.op_class = OC_LUI;
            dec.imm      = imm_u_s;
            dec.rd_we    = 1'b1;
         end
         OPC_AUIPC: begin
            dec.op_class = OC_AUIPC;
            dec.imm      = imm_u_s;
            dec.rd_we    = 1'b1;
         end
         OPC_JAL: begin
            dec.op_class = OC_JAL;
            dec.imm      = imm_j_s;
            dec.rd_we    = 1'b1;
         end
         OPC_JALR: begin
            dec.op_class = OC_JALR;
            dec.imm      = imm_i_s;
            dec.rs1_en   = 1'b1;
            dec.rd_we    = 1'b1;
         end
         OPC_BRANCH: begin
            dec.op_class = OC_BRANCH;
            dec.imm      = imm_b_s;
            dec.rs1_en   = 1'b1;
            dec.rs2_en   = 1'b1;
            ill_s        = ill_s | (funct3_s == 3'b010) | (funct3_s == 3'b011);
         end
         OPC_LOAD: begin
            dec.op_class = OC_LOAD;
            dec.imm      = imm_i_s;
            dec.rs1_en   = 1'b1;
            dec.rd_we    = 1'b1;
            ill_s        = ill_s | (funct3_s == 3'b011) | (funct3_s == 3'b110) | (funct3_s == 3'b111);
         end
         OPC_STORE: begin
            dec.op_class = OC_STORE;
            dec.imm      = imm_s_s;
            dec.rs1_en   = 1'b1;
            dec.rs2_en   = 1'b1;
            ill_s        = ill_s | (funct3_s > 3'b010);
         end
         OPC_OP_IMM: begin
            dec.op_class = OC_ALU_IMM;
            dec.imm      = imm_i_s;
            dec.alu_op   = alu_from_f3(funct3_s, (funct3_s == 3'b101) & instr[30]);
            dec.rs1_en   = 1'b1;
            dec.rd_we    = 1'b1;
            ill_s        = ill_s
                         | ((funct3_s == 3'b001) & (funct7_s != 7'h00))
                         | ((funct3_s == 3'b101) & (funct7_s != 7'h00) & (funct7_s != 7'h20));
         end
         OPC_OP: begin
            dec.op_class = OC_ALU_REG;
            dec.alu_op   = alu_from_f3(funct3_s, instr[30]);
            dec.rs1_en   = 1'b1;
            dec.rs2_en   = 1'b1;
            dec.rd_we    = 1'b1;
            ill_s        = ill_s
                         | ~((funct7_s == 7'h00)
                         | ((funct7_s == 7'h20) & ((funct3_s == 3'b000) | (funct3_s == 3'b101))));
         end
         OPC_MISC_MEM: begin
            dec.op_class = OC_FENCE;
         end
         OPC_SYSTEM: begin
            dec.op_class = OC_SYSTEM;
            dec.imm      = imm_i_s;
            ill_s        = ill_s | ((instr != 32'h0000_0073) & (instr != 32'h0010_0073));
         end
         default: begin
            ill_s = 1'b1;
         end
      endcase
      dec.illegal = ill_s;
      dec.rs1_en  = dec.rs1_en & ~ill_s;
      dec.rs2_en  = dec.rs2_en & ~ill_s;
      dec.rd_we   = dec.rd_we & ~ill_s & (dec.rd != 5'd0);
   end

endmodule

// File: rtl/bure_stage_id.sv
// Bure ID stage: decodes fetched instructions into a 2-entry skid buffer
// (main entry drives o_dec, skid entry absorbs one stalled arrival).
module bure_stage_id
   import bure_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_flush,
   input  logic                   i_instr_valid,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   input  logic [ADDR_WIDTH-1:0]  i_pc,
   output logic                   o_instr_ready,
   output logic                   o_dec_valid,
   input  logic                   i_dec_ready,
   output bure_dec_t              o_dec
);

   bure_dec_t dec_s;
   bure_dec_t main_r;
   bure_dec_t skid_r;
   bure_dec_t main_nxt_s;
   bure_dec_t skid_nxt_s;
   logic      main_valid_r;
   logic      skid_valid_r;
   logic      main_valid_nxt_s;
   logic      skid_valid_nxt_s;
   logic      ready_r;
   logic      xfer_in_s;
   logic      main_free_s;

   bure_decoder #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH)
   ) u_decoder (
      .instr (i_instr),
      .pc    (i_pc),
      .dec   (dec_s)
   );

   assign xfer_in_s   = i_instr_valid & ready_r;
   assign main_free_s = ~main_valid_r | i_dec_ready;

   // Skid buffer next state: skid entry refills main before new input
   always_comb begin
      main_nxt_s       = main_r;
      skid_nxt_s       = skid_r;
      main_valid_nxt_s = main_valid_r;
      skid_valid_nxt_s = skid_valid_r;
      if (i_flush) begin
         main_valid_nxt_s = 1'b0;
         skid_valid_nxt_s = 1'b0;
      end else if (main_free_s) begin
         if (skid_valid_r) begin
            main_nxt_s       = skid_r;
            main_valid_nxt_s = 1'b1;
            skid_valid_nxt_s = 1'b0;
         end else if (xfer_in_s) begin
            main_nxt_s       = dec_s;
            main_valid_nxt_s = 1'b1;
         end else begin
            main_valid_nxt_s = 1'b0;
         end
      end else if (xfer_in_s) begin
         skid_nxt_s       = dec_s;
         skid_valid_nxt_s = 1'b1;
      end else begin
         skid_valid_nxt_s = skid_valid_r;
      end
   end

   // State registers; ready is registered from the next skid occupancy
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         main_r       <= '0;
         skid_r       <= '0;
         main_valid_r <= 1'b0;
         skid_valid_r <= 1'b0;
         ready_r      <= 1'b0;
      end else begin
         main_r       <= main_nxt_s;
         skid_r       <= skid_nxt_s;
         main_valid_r <= main_valid_nxt_s;
         skid_valid_r <= skid_valid_nxt_s;
         ready_r      <= ~skid_valid_nxt_s;
      end
   end

   assign o_dec         = main_r;
   assign o_dec_valid   = main_valid_r;
   assign o_instr_ready = ready_r;

endmodule

// File: tb/tb_bure_stage_id.sv
// Directed bench for bure_stage_id: table of decode vectors streamed at
// full rate, plus hand-written reset, backpressure and flush sequences.
module tb_bure_stage_id;
   import bure_pkg::*;

   typedef struct {
      logic [31:0]    instr;
      logic           full;
      logic [4:0]     rd;
      logic [4:0]     rs1;
      logic [4:0]     rs2;
      logic [2:0]     f3;
      logic [31:0]    imm;
      logic           imm_chk;
      bure_op_class_e cls;
      bure_alu_op_e   alu;
      logic           alu_chk;
      logic           rs1_en;
      logic           rs2_en;
      logic           rd_we;
      logic           ill;
   } vec_t;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_flush = 1'b0;
   logic        i_instr_valid = 1'b0;
   logic [31:0] i_instr = 32'h0;
   logic [31:0] i_pc = 32'h0;
   logic        o_instr_ready;
   logic        o_dec_valid;
   logic        i_dec_ready = 1'b1;
   bure_dec_t   o_dec;

   int n_vec = 0;
   int n_bad = 0;
   vec_t vecs[$];

   bure_stage_id dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_flush       (i_flush),
      .i_instr_valid (i_instr_valid),
      .i_instr       (i_instr),
      .i_pc          (i_pc),
      .o_instr_ready (o_instr_ready),
      .o_dec_valid   (o_dec_valid),
      .i_dec_ready   (i_dec_ready),
      .o_dec         (o_dec)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                               input logic imm_chk, input bure_op_class_e cls, input bure_alu_op_e alu,
                               input logic alu_chk, input logic rs1_en, input logic rs2_en,
                               input logic rd_we);
      vec_t v;
      v.instr = instr; v.full = 1'b1; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3;
      v.imm = imm; v.imm_chk = imm_chk; v.cls = cls; v.alu = alu; v.alu_chk = alu_chk;
      v.rs1_en = rs1_en; v.rs2_en = rs2_en; v.rd_we = rd_we; v.ill = 1'b0;
      return v;
   endfunction

   function automatic vec_t mk_ill(input logic [31:0] instr);
      vec_t v;
      v = mk(instr, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 1'b0, OC_LUI, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      v.full = 1'b0;
      v.ill  = 1'b1;
      return v;
   endfunction

   task automatic check_vec(input vec_t v, input logic [31:0] pc);
      logic bad;
      n_vec++;
      bad = (o_dec_valid !== 1'b1) | (o_instr_ready !== 1'b1) | (o_dec.illegal !== v.ill)
          | (o_dec.rs1_en !== v.rs1_en) | (o_dec.rs2_en !== v.rs2_en) | (o_dec.rd_we !== v.rd_we);
      if (v.full) begin
         bad = bad | (o_dec.pc !== pc) | (o_dec.rd !== v.rd) | (o_dec.rs1 !== v.rs1)
             | (o_dec.rs2 !== v.rs2) | (o_dec.funct3 !== v.f3) | (o_dec.op_class !== v.cls)
             | (v.imm_chk & (o_dec.imm !== v.imm)) | (v.alu_chk & (o_dec.alu_op !== v.alu));
      end
      if (bad) begin
         n_bad++;
         $display("FAIL vec %08h: got vld=%b rdy=%b pc=%08h rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%08h cls=%0d alu=%0d en=%b%b we=%b ill=%b; expected pc=%08h rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%08h cls=%0d alu=%0d en=%b%b we=%b ill=%b",
                  v.instr, o_dec_valid, o_instr_ready, o_dec.pc, o_dec.rd, o_dec.rs1, o_dec.rs2,
                  o_dec.funct3, o_dec.imm, o_dec.op_class, o_dec.alu_op, o_dec.rs1_en, o_dec.rs2_en,
                  o_dec.rd_we, o_dec.illegal, pc, v.rd, v.rs1, v.rs2, v.f3, v.imm, v.cls, v.alu,
                  v.rs1_en, v.rs2_en, v.rd_we, v.ill);
      end
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc);
      i_instr_valid = 1'b1;
      i_instr       = instr;
      i_pc          = pc;
   endtask

   initial begin
      //     instr         rd     rs1    rs2    f3    imm           ichk  class       alu      achk  r1e   r2e   we
      vecs.push_back(mk(32'h11400093, 5'd1,  5'd0, 5'd20, 3'd0, 32'h00000114, 1'b1, OC_ALU_IMM, ALU_ADD,  1'b1, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(32'hFE208EE3, 5'd29, 5'd1, 5'd2,  3'd0, 32'hFFFFFFFC, 1'b1, OC_BRANCH,  ALU_ADD,  1'b0, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(32'h002081B3, 5'd3,  5'd1, 5'd2,  3'd0, 32'h0,        1'b0, OC_ALU_REG, ALU_ADD,  1'b1, 1'b1, 1'b1, 1'b1));
      vecs.push_back(mk(32'h407302B3, 5'd5,  5'd6, 5'd7,  3'd0, 32'h0,        1'b0, OC_ALU_REG, ALU_SUB,  1'b1, 1'b1, 1'b1, 1'b1));
      vecs.push_back(mk(32'h403150B3, 5'd1,  5'd2, 5'd3,  3'd5, 32'h0,        1'b0, OC_ALU_REG, ALU_SRA,  1'b1, 1'b1, 1'b1, 1'b1));
      vecs.push_back(mk(32'h40315093, 5'd1,  5'd2, 5'd3,  3'd5, 32'h00000403, 1'b1, OC_ALU_IMM, ALU_SRA,  1'b1, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(32'hFFF12093, 5'd1,  5'd2, 5'd31, 3'd2, 32'hFFFFFFFF, 1'b1, OC_ALU_IMM, ALU_SLT,  1'b1, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(32'h123452B7, 5'd5,  5'd8, 5'd3,  3'd5, 32'h12345000, 1'b1, OC_LUI,     ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(32'h00001117, 5'd2,  5'd0, 5'd0,  3'd1, 32'h00001000, 1'b1, OC_AUIPC,   ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(32'h008000EF, 5'd1,  5'd0, 5'd8,  3'd0, 32'h00000008, 1'b1, OC_JAL,     ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(32'h004100E7, 5'd1,  5'd2, 5'd4,  3'd0, 32'h00000004, 1'b1, OC_JALR,    ALU_ADD,  1'b0, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(32'hFE20AE23, 5'd28, 5'd1, 5'd2,  3'd2, 32'hFFFFFFFC, 1'b1, OC_STORE,   ALU_ADD,  1'b0, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(32'h0000A003, 5'd0,  5'd1, 5'd0,  3'd2, 32'h0,        1'b1, OC_LOAD,    ALU_ADD,  1'b0, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(32'h00000073, 5'd0,  5'd0, 5'd0,  3'd0, 32'h0,        1'b1, OC_SYSTEM,  ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(32'h00100073, 5'd0,  5'd0, 5'd1,  3'd0, 32'h0,        1'b0, OC_SYSTEM,  ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(32'h0FF0000F, 5'd0,  5'd0, 5'd31, 3'd0, 32'h0,        1'b0, OC_FENCE,   ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk_ill(32'hAAAAAAAA));
      vecs.push_back(mk_ill(32'hAAAAAAAB));
      vecs.push_back(mk_ill(32'h00200073));
      vecs.push_back(mk_ill(32'h403110B3));
      vecs.push_back(mk_ill(32'h40311093));
      vecs.push_back(mk_ill(32'hFE20BE23));
      vecs.push_back(mk_ill(32'hFE20AEE3));
      vecs.push_back(mk_ill(32'h0000E083));

      // reset state
      tick();
      tick();
      chk("rst_ready", {31'd0, o_instr_ready}, 32'd0);
      chk("rst_valid", {31'd0, o_dec_valid}, 32'd0);
      chk("rst_dec_zero", {31'd0, (o_dec == '0)}, 32'd1);
      i_rst = 1'b0;
      tick();
      chk("post_rst_ready", {31'd0, o_instr_ready}, 32'd1);
      chk("post_rst_valid", {31'd0, o_dec_valid}, 32'd0);

      // full-rate stream through the decode table
      i_dec_ready = 1'b1;
      for (int k = 0; k < vecs.size(); k++) begin
         push(vecs[k].instr, 32'(k * 4));
         tick();
         check_vec(vecs[k], 32'(k * 4));
      end
      i_instr_valid = 1'b0;
      tick();
      chk("stream_drain_valid", {31'd0, o_dec_valid}, 32'd0);

      // backpressure: third instruction must wait until main drains
      i_dec_ready = 1'b0;
      push(32'h11400093, 32'h100);
      tick();
      chk("bp1_ready", {31'd0, o_instr_ready}, 32'd1);
      chk("bp1_pc", o_dec.pc, 32'h100);
      push(32'h21400093, 32'h104);
      tick();
      chk("bp2_ready", {31'd0, o_instr_ready}, 32'd0);
      chk("bp2_pc_held", o_dec.pc, 32'h100);
      push(32'hAAAAAAAB, 32'h108);
      tick();
      tick();
      chk("bp3_ready", {31'd0, o_instr_ready}, 32'd0);
      chk("bp3_imm_held", o_dec.imm, 32'h114);
      i_dec_ready = 1'b1;
      tick();
      chk("bp4_pc", o_dec.pc, 32'h104);
      chk("bp4_imm", o_dec.imm, 32'h214);
      chk("bp4_ready", {31'd0, o_instr_ready}, 32'd1);
      tick();
      i_instr_valid = 1'b0;
      chk("bp5_pc", o_dec.pc, 32'h108);
      chk("bp5_ill", {31'd0, o_dec.illegal}, 32'd1);
      chk("bp5_valid", {31'd0, o_dec_valid}, 32'd1);
      tick();
      chk("bp6_valid", {31'd0, o_dec_valid}, 32'd0);

      // flush with both entries occupied and a new input offered
      i_dec_ready = 1'b0;
      push(32'h11400093, 32'h200);
      tick();
      push(32'h21400093, 32'h204);
      tick();
      chk("fl_full_ready", {31'd0, o_instr_ready}, 32'd0);
      push(32'h002081B3, 32'h208);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      i_instr_valid = 1'b0;
      chk("fl_valid", {31'd0, o_dec_valid}, 32'd0);
      chk("fl_ready", {31'd0, o_instr_ready}, 32'd1);
      i_dec_ready = 1'b1;
      push(32'h123452B7, 32'h20C);
      tick();
      i_instr_valid = 1'b0;
      chk("fl_next_valid", {31'd0, o_dec_valid}, 32'd1);
      chk("fl_next_pc", o_dec.pc, 32'h20C);
      chk("fl_next_imm", o_dec.imm, 32'h12345000);
      tick();
      chk("fl_nothing_left", {31'd0, o_dec_valid}, 32'd0);

      // reset in the middle of a stalled stream, flush ignored under reset
      i_dec_ready = 1'b0;
      push(32'h11400093, 32'h300);
      tick();
      push(32'h21400093, 32'h304);
      tick();
      i_rst = 1'b1;
      i_flush = 1'b1;
      tick();
      chk("mrst1_valid", {31'd0, o_dec_valid}, 32'd0);
      chk("mrst1_ready", {31'd0, o_instr_ready}, 32'd0);
      chk("mrst1_dec_zero", {31'd0, (o_dec == '0)}, 32'd1);
      tick();
      chk("mrst2_ready", {31'd0, o_instr_ready}, 32'd0);
      chk("mrst2_dec_zero", {31'd0, (o_dec == '0)}, 32'd1);
      i_rst = 1'b0;
      i_flush = 1'b0;
      i_instr_valid = 1'b0;
      i_dec_ready = 1'b1;
      tick();
      chk("mrst_rel_ready", {31'd0, o_instr_ready}, 32'd1);
      chk("mrst_rel_valid", {31'd0, o_dec_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bure_stage_id.md
# bure_stage_id

Instruction decode stage of the Bure core pipeline, directly downstream of `bure_stage_if`. It accepts fetched instruction words over a valid/ready handshake and decodes RV32I fields, immediates and operation class into a packed decode bundle. It presents the bundle to the execute stage through a 2-entry skid buffer, which provides full throughput and a registered upstream ready. It also supports a synchronous pipeline flush.

## Interface
Parameters:
- `INSTR_WIDTH`, 32: instruction word width; only 32 is supported.
- `ADDR_WIDTH`, 32: PC width.
- `DATA_WIDTH`, 32: immediate width; immediates are sign-extended to this width.

Ports:
- `i_clk`  in  1: clock; all logic is on the rising edge.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_flush`  in  1: flushes the stage (branch redirect or pipeline reset).
- `i_instr_valid`  in  1: instruction from IF is valid.
- `i_instr`  in  INSTR_WIDTH: instruction word.
- `i_pc`  in  ADDR_WIDTH: PC of `i_instr`.
- `o_instr_ready`  out  1: stage can accept an instruction; driven from a register.
- `o_dec_valid`  out  1: decode bundle is valid.
- `i_dec_ready`  in  1: execute stage accepts the bundle.
- `o_dec`  out  `bure_dec_t`: decode bundle.

## Operation
- Transfer rules:
  - A transfer in occurs when `i_instr_valid && o_instr_ready`.
  - A transfer out occurs when `o_dec_valid && i_dec_ready`.
- Decode is combinational on `i_instr`/`i_pc`. The result is written into the skid buffer; no decode happens on the output side.
- `bure_dec_t` fields:
  - `pc`, `rd`, `rs1`, `rs2`
  - `imm` (DATA_WIDTH)
  - `op_class`: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU_IMM, ALU_REG, FENCE, SYSTEM
  - `alu_op`: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  - `funct3`
  - `rs1_en`, `rs2_en`, `rd_we`
  - `illegal`
- Immediate formats are I/S/B/U/J, all sign-extended. B and J immediates have bit0 = 0. U immediates are `{instr[31:12], 12'b0}`.
- `rd_we` is 0 when `rd == 0`, and 0 for BRANCH, STORE, FENCE and illegal instructions.
- An instruction is illegal when any of the following holds:
  - `instr[1:0] != 2'b11`
  - the opcode is unknown
  - OP has `funct7` other than 0x00/0x20, or 0x20 with funct3 ∉ {000, 101}
  - OP-IMM shifts have a bad `funct7`
  - BRANCH has funct3 ∈ {010, 011}
  - LOAD has funct3 ∈ {011, 110, 111}
  - STORE has funct3 > 010
  - SYSTEM is anything other than ECALL/EBREAK
- Illegal instructions are still passed downstream with `illegal = 1` and all enables 0.
- Skid buffer structure: a main entry drives `o_dec`; a skid entry catches an input that arrives while the main entry is stalled.
  - Capacity is 2.
  - `o_instr_ready = !skid_valid`.
  - When the main entry is empty or draining, it is refilled from the skid entry first, then from the input.
  - Order is strictly FIFO.
- Flush: on the edge where `i_flush = 1`, both entries are invalidated and the input of that cycle is dropped. The next cycle has `o_dec_valid = 0` and `o_instr_ready = 1`.
- Flush is ignored while `i_rst = 1`, because reset dominates.

## Timing
- Latency: an instruction accepted on edge N appears on `o_dec` with `o_dec_valid = 1` after edge N (available in cycle N+1).
- Throughput is 1 per cycle when `i_dec_ready` is held high.
- Reset values:
  - `o_dec_valid = 0`
  - `o_dec` all zero
  - `o_instr_ready = 0` while `i_rst` is high, then 1 on the first cycle after release
- With `i_dec_ready = 0`:
  - Two instructions are accepted.
  - `o_instr_ready` falls in the cycle after the second acceptance.
  - It rises in the cycle after the first transfer out.
- `o_dec` holds stable while `o_dec_valid && !i_dec_ready`.
- Simultaneous transfer in and out with the main entry full and the skid entry empty: the main entry takes the new instruction and the skid entry stays empty.
- A reset or flush asserted mid-stall discards both entries; no partial bundle is emitted.

## Structure
- `bure_pkg` holds:
  - `bure_dec_t`
  - `bure_op_class_e`
  - `bure_alu_op_e`
  - RV32I opcode localparams
- Sub-module `bure_decoder`: purely combinational instruction-to-`bure_dec_t` decode.
- `bure_stage_id` instantiates `bure_decoder` and contains the skid buffer.

## Test plan
- Simple decode: `0x11400093` (addi x1,x0,0x114) at pc 0x0 → next cycle:
  - `rd = 1`, `rs1 = 0`, `imm = 0x114`, `alu_op = ADD`, `op_class = ALU_IMM`
  - `rd_we = 1`, `illegal = 0`
- Branch immediate: `0xFE208EE3` (beq x1,x2,-4) →
  - `imm = 0xFFFFFFFC`, `rs1 = 1`, `rs2 = 2`
  - `rs2_en = 1`, `rd_we = 0`
- Illegal instruction: `0xAAAAAAAA` → `illegal = 1`, `rd_we = 0`, still emitted with `o_dec_valid = 1`.
- Backpressure: hold `i_dec_ready = 0` and stream 0x114, 0x214, 0xAAAAAAAB →
  - Only the first two are accepted and `o_instr_ready` goes to 0.
  - After release, the bundles drain in order with no loss or duplication.
- Flush while full: assert `i_flush` for 1 cycle with both entries valid → next cycle `o_dec_valid = 0`, `o_instr_ready = 1`; the next fetched instruction decodes normally.
- Reset mid-stream: assert `i_rst` for 2 cycles during streaming → all outputs are zero/0 during reset, and `o_instr_ready = 1` in the first cycle after release.
